// File: rtl/serial_port.sv
// Processor-facing UART bridge: TX/RX byte FIFOs in front of an 8N1 transmitter and a
// midpoint-sampling receiver with a two-flop input synchroniser.
module serial_port_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       empty_o,
   output logic       full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          push_ok;
   logic          pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   // a pop on the same edge frees the slot, so a push into a full FIFO still lands
   assign push_ok = push_i && (!full_o || pop_ok);
   assign data_o  = mem_q[rd_q];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_ok) rd_q <= rd_q + AW'(1);
         if (push_ok && !pop_ok)      cnt_q <= cnt_q + (AW+1)'(1);
         else if (pop_ok && !push_ok) cnt_q <= cnt_q - (AW+1)'(1);
      end
   end
endmodule

module serial_port #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] wr_data_in,
   input  logic       wren_in,
   input  logic       rden_in,
   output logic [7:0] rd_data_out,
   output logic       valid_out,
   output logic       ready_out,
   input  logic       uart_rx_in,
   output logic       uart_tx_out,
   output logic       rx_frame_err_out
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

   state_e        tx_state_q;
   logic [CW-1:0] tx_cnt_q;
   logic [7:0]    tx_shift_q;
   logic [2:0]    tx_bit_q;
   logic          tx_line_q;
   logic [7:0]    tx_head;
   logic          tx_empty;
   logic          tx_full;
   logic          tx_pop;

   state_e        rx_state_q;
   logic [CW-1:0] rx_cnt_q;
   logic [7:0]    rx_shift_q;
   logic [2:0]    rx_bit_q;
   logic          rx_meta_q;
   logic          rx_sync_q;
   logic          rx_prev_q;
   logic          rx_err_q;
   logic          rx_empty;
   logic          rx_full;
   logic          rx_push;

   assign tx_pop = !tx_empty &&
                   (tx_state_q == IDLE || (tx_state_q == STOP && tx_cnt_q == '0));

   serial_port_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock(clock), .reset(reset), .push_i(wren_in), .data_i(wr_data_in),
      .pop_i(tx_pop), .data_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state_q <= IDLE;
         tx_cnt_q   <= '0;
         tx_shift_q <= 8'h00;
         tx_bit_q   <= 3'd0;
         tx_line_q  <= 1'b1;
      end else begin
         case (tx_state_q)
            IDLE, STOP: begin
               if (tx_state_q == STOP && tx_cnt_q != '0) begin
                  tx_cnt_q <= tx_cnt_q - CW'(1);
               end else if (tx_pop) begin
                  tx_shift_q <= tx_head;
                  tx_line_q  <= 1'b0;
                  tx_cnt_q   <= BIT_TC;
                  tx_state_q <= START;
               end else begin
                  tx_state_q <= IDLE;
               end
            end
            START, DATA: begin
               if (tx_cnt_q != '0) begin
                  tx_cnt_q <= tx_cnt_q - CW'(1);
               end else begin
                  tx_cnt_q <= BIT_TC;
                  if (tx_state_q == DATA && tx_bit_q == 3'd7) begin
                     tx_line_q  <= 1'b1;
                     tx_state_q <= STOP;
                  end else begin
                     tx_line_q  <= tx_shift_q[0];
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     tx_bit_q   <= (tx_state_q == START) ? 3'd0 : tx_bit_q + 3'd1;
                     tx_state_q <= DATA;
                  end
               end
            end
            default: tx_state_q <= IDLE;
         endcase
      end
   end

   assign rx_push = (rx_state_q == STOP) && (rx_cnt_q == '0) && rx_sync_q &&
                    (!rx_full || (rden_in && !rx_empty));

   serial_port_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock(clock), .reset(reset), .push_i(rx_push), .data_i(rx_shift_q),
      .pop_i(rden_in), .data_o(rd_data_out), .empty_o(rx_empty), .full_o(rx_full)
   );

   // rx_prev_q trails the synchroniser so the falling edge is seen on clean samples only
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= IDLE;
         rx_cnt_q   <= '0;
         rx_shift_q <= 8'h00;
         rx_bit_q   <= 3'd0;
         rx_err_q   <= 1'b0;
      end else begin
         rx_meta_q <= uart_rx_in;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         rx_err_q  <= 1'b0;
         case (rx_state_q)
            IDLE: begin
               if (rx_prev_q && !rx_sync_q) begin
                  rx_cnt_q   <= HALF_TC;
                  rx_state_q <= START;
               end
            end
            START: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_q <= rx_cnt_q - CW'(1);
               end else if (rx_sync_q) begin
                  rx_state_q <= IDLE;
               end else begin
                  rx_cnt_q   <= BIT_TC;
                  rx_bit_q   <= 3'd0;
                  rx_state_q <= DATA;
               end
            end
            DATA: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_q <= rx_cnt_q - CW'(1);
               end else begin
                  rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  rx_cnt_q   <= BIT_TC;
                  rx_bit_q   <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_q <= STOP;
               end
            end
            STOP: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_q <= rx_cnt_q - CW'(1);
               end else begin
                  rx_err_q   <= !rx_sync_q;
                  rx_state_q <= IDLE;
               end
            end
            default: rx_state_q <= IDLE;
         endcase
      end
   end

   assign uart_tx_out      = tx_line_q;
   assign ready_out        = !tx_full;
   assign valid_out        = !rx_empty;
   assign rx_frame_err_out = rx_err_q;
endmodule
